tx_controller: RTL and testbench
================================

Name: tx_controller

Overview:
- Transmit-side counterpart of the UART receive command parser.
- On a display command pulse, it snapshots the ALU result and flags, builds a fixed 4-byte response frame, and streams it byte-by-byte into uart_tx.
- Uses uart_tx's start/busy/done handshake.
- Sits between the ALU result register and uart_tx in the top level.

Parameters:
- NB_DATA, 8: ALU result width, legal range 1..8; zero-extended to 8 bits in the frame.
- HDR_BYTE, 8'hA5: frame header byte.
- FRAME_LEN, 4: bytes per frame; fixed at 4 (header, result, flags, checksum).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- display_cmd_pulse  in  1  one-cycle request to send the current result
- alu_result  in  NB_DATA  ALU result
- alu_flags  in  3  [2]=overflow, [1]=carry, [0]=zero
- tx_busy  in  1  uart_tx is shifting a byte
- tx_done  in  1  one-cycle pulse from uart_tx after the stop bit
- tx_start  out  1  one-cycle pulse that launches tx_data in uart_tx
- tx_data  out  8  byte presented to uart_tx; stable while the byte is in flight
- busy  out  1  high whenever state is not S_IDLE
- frame_done  out  1  one-cycle pulse after the last byte's tx_done
- cmd_dropped  out  1  one-cycle pulse when a display command arrives while busy

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=S_IDLE, byte index=0, snapshot registers=0.
  - tx_start=0, tx_data=8'h00, frame_done=0, cmd_dropped=0.
  - Reset mid-frame aborts immediately; the partial frame is not resumed.
- Frame byte order:
  - byte0=HDR_BYTE
  - byte1={zero-ext, result_snap}
  - byte2={5'b0, flags_snap}
  - byte3=byte0^byte1^byte2
- Checksum is computed from the snapshot registers, never from live inputs.
- State machine:
  - S_IDLE: if display_cmd_pulse, capture alu_result and alu_flags into the snapshot registers, set idx=0, go to S_SEND.
  - S_SEND: wait for tx_busy==0. On that edge, register tx_start=1 and tx_data=frame[idx], then go to S_WAIT.
  - S_WAIT:
    - tx_start is high for exactly the first cycle of S_WAIT, then 0.
    - tx_done is ignored in the cycle tx_start is high.
    - On tx_done with idx<3: idx++, go to S_SEND.
    - On tx_done with idx==3: register frame_done=1, go to S_IDLE.
- Latency:
  - display_cmd_pulse high in cycle N with tx_busy low → tx_start high in cycle N+2.
  - Inter-byte gap ≥ 2 cycles after tx_done, plus any remaining tx_busy time.
- tx_data holds its value from the tx_start cycle until the next tx_start; it is not cleared at end of frame.
- Simultaneous/overlapping events:
  - display_cmd_pulse while busy: command ignored, snapshot untouched, cmd_dropped pulses the next cycle.
  - display_cmd_pulse in the same cycle frame_done is high (state already S_IDLE): accepted normally.
- tx_busy high on entry to S_SEND: hold in S_SEND indefinitely with no start issued (no timeout).
- Spurious tx_done in S_IDLE or S_SEND: ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (common with the receive controller):
  - CMD_DISPLAY (8'hD1), HDR_BYTE, FRAME_LEN.
  - 2-bit state encodings: S_IDLE=0, S_SEND=1, S_WAIT=2.
  - Flag bit indices.
- No sub-module: the frame mux and checksum are a small combinational case on idx inside this block.

Test Plan:
- Basic frame:
  - Stimulus: alu_result=8'h3C, flags=3'b010, one pulse, uart_tx model with 10-cycle busy.
  - Response: tx_data sequence A5,3C,02,9B; exactly 4 tx_start pulses; frame_done once after the 4th tx_done; busy low afterwards.
- Snapshot isolation:
  - Stimulus: pulse with result 8'hFF, flags 3'b101; change inputs to 8'h00 one cycle later.
  - Response: frame A5,FF,05,5F.
- Dropped command:
  - Stimulus: second pulse during byte 1.
  - Response: cmd_dropped pulses one cycle later; frame unchanged; only 4 bytes sent.
- Back-pressure:
  - Stimulus: hold tx_busy high for 50 cycles before the first byte.
  - Response: no tx_start while busy; tx_start in the cycle after the edge where tx_busy is sampled low.
- Mid-frame reset:
  - Stimulus: assert reset_n low while waiting on byte 2.
  - Response: all outputs return to reset values asynchronously; a new pulse after reset sends a complete fresh frame from the header.
- Back-to-back:
  - Stimulus: pulse in the same cycle frame_done is high.
  - Response: second frame accepted; no cmd_dropped.

Source files
------------

// File: rtl/tx_controller_pkg.sv
// Constants and state encoding shared by the UART command receive and response transmit controllers.
package tx_controller_pkg;

    localparam logic [7:0] CMD_DISPLAY = 8'hD1;
    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam int         FRAME_LEN   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/tx_controller.sv
// Snapshots the ALU result/flags on a display command and streams a 4-byte
// response frame (header, result, flags, checksum) into uart_tx.
module tx_controller #(
    parameter int         NB_DATA   = 8,
    parameter logic [7:0] HDR_BYTE  = tx_controller_pkg::HDR_BYTE,
    parameter int         FRAME_LEN = tx_controller_pkg::FRAME_LEN
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               display_cmd_pulse,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic [2:0]         alu_flags,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic               busy,
    output logic               frame_done,
    output logic               cmd_dropped
);
    import tx_controller_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

    state_t             state, state_nxt;
    logic [1:0]         idx;
    logic [NB_DATA-1:0] result_snap;
    logic [2:0]         flags_snap;
    logic [7:0]         result_ext, flags_ext, frame_byte;
    logic               accept, done_ok;
    logic               start_nxt, frame_done_nxt, cmd_dropped_nxt;
    logic [7:0]         data_nxt;

    assign accept  = (state == S_IDLE) && display_cmd_pulse;
    // The tx_done of the previous byte may still be visible while tx_start is high.
    assign done_ok = (state == S_WAIT) && tx_done && !tx_start;
    assign busy    = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of always block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every variable gets a default at the top of an always_comb block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)   state_nxt = S_SEND;
            S_SEND: if (!tx_busy) state_nxt = S_WAIT;
            S_WAIT: if (done_ok)  state_nxt = (idx == LAST_IDX) ? S_IDLE : S_SEND;
            default:              state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        result_ext                = '0;
        result_ext[NB_DATA-1:0]   = result_snap;
        flags_ext                 = {5'b0, flags_snap};
        case (idx)
            2'd0:    frame_byte = HDR_BYTE;
            2'd1:    frame_byte = result_ext;
            2'd2:    frame_byte = flags_ext;
            default: frame_byte = HDR_BYTE ^ result_ext ^ flags_ext;
        endcase
    end

    always_comb begin
        start_nxt       = (state == S_SEND) && !tx_busy;
        data_nxt        = start_nxt ? frame_byte : tx_data;
        frame_done_nxt  = done_ok && (idx == LAST_IDX);
        cmd_dropped_nxt = display_cmd_pulse && (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            frame_done  <= 1'b0;
            cmd_dropped <= 1'b0;
        end else begin
            tx_start    <= start_nxt;
            tx_data     <= data_nxt;
            frame_done  <= frame_done_nxt;
            cmd_dropped <= cmd_dropped_nxt;
        end
    end

    // Snapshot is taken only on an accepted command; a dropped one leaves it untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= 2'd0;
            result_snap <= '0;
            flags_snap  <= 3'b000;
        end else if (accept) begin
            idx         <= 2'd0;
            result_snap <= alu_result;
            flags_snap  <= {alu_flags[FLAG_OVF], alu_flags[FLAG_CARRY], alu_flags[FLAG_ZERO]};
        end else if (done_ok && (idx != LAST_IDX)) begin
            idx <= idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_tx_controller.sv
// Self-checking bench for tx_controller: uart_tx behavioural model, frame scoreboard, directed and random frames.
module tb_tx_controller;

    localparam logic [7:0] HDR = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       display_cmd_pulse = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic [2:0] alu_flags = 3'b000;
    wire        tx_busy;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;
    logic       cmd_dropped;

    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    assign tx_busy = model_busy | hold_busy;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int busy_len = 10;
    int cnt = 0;

    logic [7:0] bytes[$];
    int start_cyc[$];
    int done_cyc[$];
    int fd_cyc[$];
    int drop_cyc[$];

    tx_controller #(.NB_DATA(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .display_cmd_pulse (display_cmd_pulse),
        .alu_result        (alu_result),
        .alu_flags         (alu_flags),
        .tx_busy           (tx_busy),
        .tx_done           (tx_done),
        .tx_start          (tx_start),
        .tx_data           (tx_data),
        .busy              (busy),
        .frame_done        (frame_done),
        .cmd_dropped       (cmd_dropped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model plus output monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!reset_n) begin
            model_busy = 1'b0;
            cnt = 0;
        end else begin
            if (tx_start) begin
                bytes.push_back(tx_data);
                start_cyc.push_back(cyc);
                model_busy = 1'b1;
                cnt = busy_len;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_busy = 1'b0;
                    tx_done = 1'b1;
                    done_cyc.push_back(cyc);
                end
            end
            if (frame_done)  fd_cyc.push_back(cyc);
            if (cmd_dropped) drop_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        bytes.delete();
        start_cyc.delete();
        done_cyc.delete();
        fd_cyc.delete();
        drop_cyc.delete();
    endtask

    task automatic pulse(input logic [7:0] r, input logic [2:0] f, output int pc);
        alu_result = r;
        alu_flags = f;
        display_cmd_pulse = 1'b1;
        pc = cyc;
        step();
        display_cmd_pulse = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (bytes.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(bytes.size() >= n), 32'd1);
    endtask

    task automatic wait_fd(input int n, input int budget, input string tag);
        int k = 0;
        while (fd_cyc.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(fd_cyc.size() >= n), 32'd1);
    endtask

    // Reference frame straight from the byte-order rules.
    task automatic check_frame(input string tag, input int base, input logic [7:0] r, input logic [2:0] f);
        logic [7:0] exp_b[4];
        logic [31:0] obs;
        exp_b[0] = HDR;
        exp_b[1] = r;
        exp_b[2] = {5'b0, f};
        exp_b[3] = exp_b[0] ^ exp_b[1] ^ exp_b[2];
        for (int i = 0; i < 4; i++) begin
            obs = (base + i < bytes.size()) ? 32'(bytes[base + i]) : 32'hDEAD_BEEF;
            check($sformatf("%s_b%0d", tag, i), obs, 32'(exp_b[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"},    32'(tx_start),    32'd0);
        check({tag, "_tx_data"},     32'(tx_data),     32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_frame_done"},  32'(frame_done),  32'd0);
        check({tag, "_cmd_dropped"}, 32'(cmd_dropped), 32'd0);
    endtask

    initial begin
        int pc, pc2, rel;
        logic [7:0] r;
        logic [2:0] f;

        // Asynchronous reset with no clock edge involved
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Basic frame with 10-cycle uart_tx busy time
        busy_len = 10;
        clear_log();
        pulse(8'h3C, 3'b010, pc);
        wait_fd(1, 300, "basic_tmo");
        check_frame("basic", 0, 8'h3C, 3'b010);
        check("basic_starts", 32'(bytes.size()), 32'd4);
        check("basic_fd_cnt", 32'(fd_cyc.size()), 32'd1);
        check("basic_latency", 32'(start_cyc.size() > 0 ? start_cyc[0] - pc : -1), 32'd2);
        check("basic_gap", 32'(start_cyc.size() > 1 && done_cyc.size() > 0 ? start_cyc[1] - done_cyc[0] : -1), 32'd2);
        check("basic_fd_time", 32'(done_cyc.size() > 3 ? fd_cyc[0] - done_cyc[3] : -1), 32'd1);
        step();
        check("basic_busy_after", 32'(busy), 32'd0);
        check("basic_no_drop", 32'(drop_cyc.size()), 32'd0);
        repeat (5) step();
        check("basic_data_hold", 32'(tx_data), 32'h9B);

        // Snapshot isolation: inputs change right after the command
        clear_log();
        pulse(8'hFF, 3'b101, pc);
        alu_result = 8'h00;
        alu_flags = 3'b000;
        wait_fd(1, 300, "snap_tmo");
        check_frame("snap", 0, 8'hFF, 3'b101);

        // Dropped command during byte 1
        clear_log();
        pulse(8'h12, 3'b001, pc);
        wait_bytes(2, 100, "drop_tmo_b1");
        step();
        pulse(8'hEE, 3'b111, pc2);
        wait_fd(1, 300, "drop_tmo_fd");
        repeat (30) step();
        check("drop_nbytes", 32'(bytes.size()), 32'd4);
        check_frame("drop", 0, 8'h12, 3'b001);
        check("drop_cnt", 32'(drop_cyc.size()), 32'd1);
        check("drop_time", 32'(drop_cyc.size() > 0 ? drop_cyc[0] - pc2 : -1), 32'd1);

        // Back-pressure: uart_tx busy for 50 cycles before the first byte
        clear_log();
        hold_busy = 1'b1;
        pulse(8'h5A, 3'b100, pc);
        repeat (50) step();
        check("bp_no_start", 32'(bytes.size()), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        rel = cyc;
        hold_busy = 1'b0;
        wait_bytes(1, 20, "bp_tmo_b0");
        check("bp_start_time", 32'(start_cyc.size() > 0 ? start_cyc[0] - rel : -1), 32'd1);
        wait_fd(1, 300, "bp_tmo_fd");
        check_frame("bp", 0, 8'h5A, 3'b100);

        // Reset while waiting on byte 2, then a fresh frame
        clear_log();
        pulse(8'h77, 3'b011, pc);
        wait_bytes(3, 200, "mrst_tmo_b2");
        repeat (3) step();
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("mrst");
        repeat (2) step();
        reset_n = 1'b1;
        step();
        clear_log();
        pulse(8'hC3, 3'b110, pc);
        wait_fd(1, 300, "mrst_tmo_fd");
        check("mrst_nbytes", 32'(bytes.size()), 32'd4);
        check_frame("mrst", 0, 8'hC3, 3'b110);

        // Back-to-back: new command in the frame_done cycle
        clear_log();
        pulse(8'h81, 3'b000, pc);
        wait_fd(1, 300, "b2b_tmo_fd1");
        check("b2b_fd_now", 32'(frame_done), 32'd1);
        pulse(8'h42, 3'b011, pc2);
        wait_fd(2, 300, "b2b_tmo_fd2");
        check("b2b_nbytes", 32'(bytes.size()), 32'd8);
        check_frame("b2b_f1", 0, 8'h81, 3'b000);
        check_frame("b2b_f2", 4, 8'h42, 3'b011);
        check("b2b_no_drop", 32'(drop_cyc.size()), 32'd0);

        // Random frames with random uart_tx busy time
        for (int it = 0; it < 6; it++) begin
            busy_len = int'($urandom_range(1, 12));
            r = 8'($urandom);
            f = 3'($urandom);
            clear_log();
            pulse(r, f, pc);
            wait_fd(1, 300, $sformatf("rnd%0d_tmo", it));
            check($sformatf("rnd%0d_nbytes", it), 32'(bytes.size()), 32'd4);
            check_frame($sformatf("rnd%0d", it), 0, r, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
